// File: rtl/lr35902_dma.sv
// LR35902 OAM DMA engine: a write to FF46 copies 160 bytes from {src, 0x00..0x9F}
// into OAM at four clocks per byte, after a four-clock start-up delay.
module lr35902_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write,
    input  logic [7:0]  reg_din,
    output logic [7:0]  reg_dout,
    output logic        active,
    output logic        drv_ext,
    output logic [15:0] adr_rd,
    output logic        rd,
    input  logic [7:0]  data_in,
    output logic [7:0]  adr_wr,
    output logic        wr,
    output logic [7:0]  data_out
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER
    } state_t;

    localparam logic [7:0] LAST_INDEX = 8'h9F;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] phase;
    logic [1:0] phase_nxt;
    logic [7:0] index;
    logic [7:0] index_nxt;
    logic [7:0] src_hi;
    logic [7:0] src_nxt;
    logic [7:0] eff_nxt;
    logic       xfer_nxt;

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        index_nxt = index;
        src_nxt   = src_hi;
        if (reg_write) begin
            state_nxt = START;
            phase_nxt = 2'd0;
            index_nxt = 8'd0;
            src_nxt   = reg_din;
        end else begin
            case (state)
                START: begin
                    phase_nxt = phase + 2'd1;
                    if (phase == 2'd3) begin
                        state_nxt = XFER;
                        index_nxt = 8'd0;
                    end
                end
                XFER: begin
                    phase_nxt = phase + 2'd1;
                    if (phase == 2'd3) begin
                        if (index == LAST_INDEX) begin
                            state_nxt = IDLE;
                            index_nxt = 8'd0;
                        end else begin
                            index_nxt = index + 8'd1;
                        end
                    end
                end
                default: begin
                    phase_nxt = 2'd0;
                    index_nxt = 8'd0;
                end
            endcase
        end
    end

    // Echo RAM at E000-FDFF mirrors C000-DDFF.
    assign eff_nxt  = (src_nxt >= 8'hE0) ? (src_nxt - 8'h20) : src_nxt;
    assign xfer_nxt = (state_nxt == XFER);

    // NOTE: outputs are decoded from the next-state values and registered here, so they
    // change on the same edge as the state they describe and never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            phase    <= 2'd0;
            index    <= 8'd0;
            src_hi   <= 8'h00;
            reg_dout <= 8'h00;
            active   <= 1'b0;
            drv_ext  <= 1'b0;
            adr_rd   <= 16'h0000;
            rd       <= 1'b0;
            adr_wr   <= 8'h00;
            wr       <= 1'b0;
            data_out <= 8'h00;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            index   <= index_nxt;
            src_hi  <= src_nxt;
            active  <= (state_nxt != IDLE);
            // VRAM (8000-9FFF) sits on the internal bus.
            drv_ext <= xfer_nxt && (eff_nxt[7:5] != 3'b100);
            adr_rd  <= xfer_nxt ? {eff_nxt, index_nxt} : 16'h0000;
            rd      <= xfer_nxt && ((phase_nxt == 2'd1) || (phase_nxt == 2'd2));
            adr_wr  <= xfer_nxt ? index_nxt : 8'h00;
            wr      <= xfer_nxt && (phase_nxt == 2'd3);
            if (reg_write) begin
                reg_dout <= reg_din;
            end
            if ((state == XFER) && (phase == 2'd2)) begin
                data_out <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_lr35902_dma.sv
// Self-checking bench for lr35902_dma: table-driven full transfers, directed restart and
// reset corners, and random writes/resets, all checked every cycle against a cycle-count model.
module tb_lr35902_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [7:0]  reg_din;
    logic [7:0]  reg_dout;
    logic        active;
    logic        drv_ext;
    logic [15:0] adr_rd;
    logic        rd;
    logic [7:0]  data_in;
    logic [7:0]  adr_wr;
    logic        wr;
    logic [7:0]  data_out;

    lr35902_dma dut (
        .clk      (clk),
        .reset    (reset),
        .reg_write(reg_write),
        .reg_din  (reg_din),
        .reg_dout (reg_dout),
        .active   (active),
        .drv_ext  (drv_ext),
        .adr_rd   (adr_rd),
        .rd       (rd),
        .data_in  (data_in),
        .adr_wr   (adr_wr),
        .wr       (wr),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Source memory returns the low address byte while it is being read.
    assign data_in = rd ? adr_rd[7:0] : 8'h00;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: a transfer is "busy" for 644 cycles counted from the write; t is the
    // number of edges since the write. Cycles 0-3 are start-up, then 4 cycles per byte.
    bit         m_busy;
    int         m_t;
    logic [7:0] m_src;
    logic [7:0] m_dout;
    logic [7:0] m_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, m_t);
    endtask

    function automatic logic [7:0] eff_of(input logic [7:0] s);
        return (s >= 8'hE0) ? s - 8'h20 : s;
    endfunction

    function automatic bit in_xfer();
        return m_busy && (m_t >= 4);
    endfunction

    function automatic int cur_index();
        return (m_t - 4) / 4;
    endfunction

    function automatic int cur_phase();
        return (m_t - 4) % 4;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_busy = 0; m_t = 0; m_src = 8'h00; m_dout = 8'h00; m_data = 8'h00;
        end else begin
            if (in_xfer() && cur_phase() == 2) m_data = 8'(cur_index());
            if (reg_write) begin
                m_busy = 1; m_t = 0; m_src = reg_din; m_dout = reg_din;
            end else if (m_busy) begin
                m_t++;
                if (m_t == 644) begin
                    m_busy = 0; m_t = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [7:0] e;
        bit         x;
        int         ph;
        logic [7:0] ix;
        x  = in_xfer();
        e  = eff_of(m_src);
        ph = x ? cur_phase() : 0;
        ix = x ? 8'(cur_index()) : 8'h00;
        check("active",   32'(active),   32'(m_busy));
        check("rd",       32'(rd),       32'(x && (ph == 1 || ph == 2)));
        check("wr",       32'(wr),       32'(x && ph == 3));
        check("adr_rd",   32'(adr_rd),   x ? 32'({e, ix}) : 32'h0);
        check("adr_wr",   32'(adr_wr),   32'(ix));
        check("drv_ext",  32'(drv_ext),  32'(x && !(e >= 8'h80 && e <= 8'h9F)));
        check("reg_dout", 32'(reg_dout), 32'(m_dout));
        check("data_out", 32'(data_out), 32'(m_data));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic write_reg(input logic [7:0] v);
        reg_din   = v;
        reg_write = 1'b1;
        step();
        reg_write = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic [7:0]  din;
        logic [15:0] first_adr;
        logic [15:0] last_adr;
        logic        drv;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int act_cnt, wr_cnt;
        logic [15:0] first_seen, last_seen;
        logic        drv_seen;

        vecs[0] = '{8'hC1, 16'hC100, 16'hC19F, 1'b1};
        vecs[1] = '{8'h80, 16'h8000, 16'h809F, 1'b0};
        vecs[2] = '{8'hFE, 16'hDE00, 16'hDE9F, 1'b1};
        vecs[3] = '{8'h9F, 16'h9F00, 16'h9F9F, 1'b0};
        vecs[4] = '{8'hE0, 16'hC000, 16'hC09F, 1'b1};
        vecs[5] = '{8'hA0, 16'hA000, 16'hA09F, 1'b1};
        vecs[6] = '{8'h7F, 16'h7F00, 16'h7F9F, 1'b1};

        reset = 1'b1; reg_write = 1'b0; reg_din = 8'h00;
        m_busy = 0; m_t = 0; m_src = 0; m_dout = 0; m_data = 0;
        run(2);
        check("reset_active", 32'(active), 32'h0);
        check("reset_reg_dout", 32'(reg_dout), 32'h0);
        reset = 1'b0;
        run(3);

        // Full transfers from a table of source pages.
        foreach (vecs[v]) begin
            write_reg(vecs[v].din);
            act_cnt = 0; wr_cnt = 0;
            first_seen = 16'h0; last_seen = 16'h0; drv_seen = 1'b0;
            if (active) act_cnt++;
            for (int c = 0; c < 650; c++) begin
                step();
                if (active) act_cnt++;
                if (wr) wr_cnt++;
                if (m_busy && m_t == 4) begin
                    first_seen = adr_rd;
                    drv_seen   = drv_ext;
                end
                if (m_busy && m_t == 643) last_seen = adr_rd;
            end
            check("active_len", 32'(act_cnt), 32'd644);
            check("wr_count", 32'(wr_cnt), 32'd160);
            check("first_adr", 32'(first_seen), 32'(vecs[v].first_adr));
            check("last_adr", 32'(last_seen), 32'(vecs[v].last_adr));
            check("drv_ext_page", 32'(drv_seen), 32'(vecs[v].drv));
            check("reg_dout_hold", 32'(reg_dout), 32'(vecs[v].din));
        end

        // Restart landing on phase 3 of index 0x50.
        write_reg(8'hC0);
        run(4 + 16'h50 * 4 + 3);
        check("restart_wr", 32'(wr), 32'h1);
        check("restart_adr_wr", 32'(adr_wr), 32'h50);
        write_reg(8'hD0);
        for (int c = 0; c < 4; c++) begin
            check("restart_start_active", 32'(active), 32'h1);
            check("restart_start_rd", 32'(rd | wr), 32'h0);
            if (c < 3) step();
        end
        step();
        check("restart_adr", 32'(adr_rd), 32'hD000);
        run(20);

        // Write in the final cycle of index 0x9F: straight back into START.
        write_reg(8'hC2);
        run(643);
        check("final_wr", 32'(wr), 32'h1);
        check("final_adr_wr", 32'(adr_wr), 32'h9F);
        write_reg(8'hC3);
        check("back_to_back_active", 32'(active), 32'h1);
        run(8);

        // Reset in the middle of index 0x20.
        write_reg(8'hC4);
        run(4 + 16'h20 * 4 + 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_active", 32'(active), 32'h0);
        check("abort_wr", 32'(wr), 32'h0);
        check("abort_reg_dout", 32'(reg_dout), 32'h0);
        run(3);

        // Reset wins over a simultaneous write.
        reset = 1'b1; reg_write = 1'b1; reg_din = 8'h55;
        step();
        reset = 1'b0; reg_write = 1'b0;
        step();
        check("reset_prio_active", 32'(active), 32'h0);
        check("reset_prio_reg_dout", 32'(reg_dout), 32'h0);

        // Random writes and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            reg_write = ($urandom_range(0, 299) == 0);
            reset     = ($urandom_range(0, 1999) == 0);
            reg_din   = 8'($urandom);
            step();
        end
        reg_write = 1'b0;
        reset = 1'b0;
        run(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lr35902_dma.md
LR35902_DMA -- requirements
Module: lr35902_dma

Interface
REQ-001 SHALL have port clk  in  1  4 MiHz system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port reg_write  in  1  one-clk write strobe for register FF46.
REQ-004 SHALL have port reg_din  in  8  source high byte written to FF46.
REQ-005 SHALL have port reg_dout  out  8  FF46 readback: last value written.
REQ-006 SHALL have port active  out  1  transfer in progress; OAM owned by DMA.
REQ-007 SHALL have port drv_ext  out  1  DMA drives the external address bus and n_read.
REQ-008 SHALL have port adr_rd  out  16  source read address.
REQ-009 SHALL have port rd  out  1  source read strobe.
REQ-010 SHALL have port data_in  in  8  source read data.
REQ-011 SHALL have port adr_wr  out  8  OAM write address.
REQ-012 SHALL have port wr  out  1  OAM write strobe.
REQ-013 SHALL have port data_out  out  8  OAM write data, registered.

Function
REQ-014 SHALL implement states IDLE, START and XFER, plus a 2-bit phase counter and an 8-bit byte index.
REQ-015 SHALL, on reg_write in any state, latch reg_din into src_hi and reg_dout, clear phase and index, and enter START on the next edge.
REQ-016 SHALL hold START for exactly 4 clk cycles with active=1, rd=0 and wr=0, then enter XFER at phase 0 and index 0.
REQ-017 SHALL use 4 clk cycles per byte in XFER, phases 0 to 3, with phase wrapping 3 to 0 and the index incrementing on that wrap.
REQ-018 SHALL, in XFER, drive adr_rd = {src_eff, index} for all four phases.
REQ-019 SHALL assert rd in phases 1 and 2 only.
REQ-020 SHALL sample data_in into data_out at the end of phase 2.
REQ-021 SHALL assert wr in phase 3 only, with adr_wr = index and data_out stable.
REQ-022 SHALL compute src_eff = src_hi - 0x20 when src_hi >= 0xE0 (echo RAM mirror), and src_eff = src_hi otherwise.
REQ-023 SHALL transfer index values 0x00 to 0x9F (160 bytes) and return to IDLE on the edge ending phase 3 of index 0x9F.
REQ-024 SHALL keep active=1 for exactly 644 clk cycles after the reg_write edge when no further write occurs.
REQ-025 SHALL assert drv_ext only in XFER and only when src_eff is not in 0x80 to 0x9F (VRAM is read internally).
REQ-026 SHALL, in IDLE, hold active, drv_ext, rd and wr at 0, and adr_rd and adr_wr at 0.
REQ-027 SHALL let a reg_write during START or XFER restart the transfer with active held at 1.
REQ-028 SHALL, when a restart lands in phase 3, still complete the wr pulse for that phase in that cycle.
REQ-029 SHALL let reg_write in the final cycle of index 0x9F produce START with no IDLE cycle in between.
REQ-030 SHALL keep reg_dout unchanged by transfer progress and equal to the last written value.

Reset
REQ-031 SHALL, on reset, enter IDLE and drive active=0, drv_ext=0, rd=0, wr=0, adr_rd=0x0000, adr_wr=0x00, data_out=0x00 and reg_dout=0x00.
REQ-032 SHALL let reset take priority over a simultaneous reg_write.
REQ-033 SHALL abort a transfer when reset is asserted mid-transfer, with no wr in the following cycle.

Verification
REQ-034 Write 0xC1, source model returns the low address byte -> active high for 644 cycles; 160 wr pulses with adr_wr 0x00 to 0x9F and data_out equal to adr_wr; adr_rd runs 0xC100 to 0xC19F; drv_ext=1.
REQ-035 Write 0x80 -> adr_rd runs 0x8000 to 0x809F; drv_ext=0 throughout; active=1.
REQ-036 Write 0xFE -> adr_rd runs 0xDE00 to 0xDE9F; reg_dout=0xFE.
REQ-037 Write 0xC0, then write 0xD0 at index 0x50 phase 3 -> wr occurs at adr_wr 0x50; 4 START cycles follow; the transfer restarts at 0xD000; active is never low.
REQ-038 Reset at index 0x20 -> the next cycle shows active=0, wr=0 and reg_dout=0x00; reset coinciding with reg_write -> stays IDLE.
